// File: rtl/label_allocator.sv
// label_allocator: hands out free 6-bit labels (1..63; label 0 is the
// reserved background label) from a 64-bit free mask. The lowest free label
// is isolated as a one-hot vector and driven to an external index encoder
// with LAT cycles of latency. A LAT+1-deep valid shift register lines the
// encoder result up with the alloc_valid pulse. Labels come back one at a
// time through rel_valid/rel_label, or all together through flush, which
// drains the in-flight grants and then re-initialises the pool.
//
// Optional feature: define LABEL_ALLOCATOR_ERR_EN to add the sticky
// err_double_free output.
module label_allocator #(
    parameter int LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alloc_req,
    output logic        alloc_rdy,
    output logic        alloc_valid,
    output logic [5:0]  alloc_label,
    input  logic        rel_valid,
    input  logic [5:0]  rel_label,
    input  logic        flush,
    output logic [6:0]  free_count,
    output logic [63:0] enc_in,
    input  logic [5:0]  enc_out
`ifdef LABEL_ALLOCATOR_ERR_EN
    ,
    output logic        err_double_free
`endif
);

    typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

    localparam logic [63:0] MASK_INIT = {{63{1'b1}}, 1'b0};
    localparam logic [6:0]  CNT_INIT  = 7'd63;

    state_t      state_q, state_d;
    logic [63:0] mask_q, mask_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] enc_q, enc_d;
    logic [LAT:0] vld_pipe_q, vld_pipe_d;
    logic        av_q, av_d;
    logic [5:0]  al_q, al_d;

    logic [63:0] grant;
    logic [63:0] rel_oh;
    logic        accept;
    logic        rel_ok;

`ifdef LABEL_ALLOCATOR_ERR_EN
    logic        err_q, err_d;
    logic        rel_bad;
`endif

    // Handshake, lowest-free isolation and release qualification, all from
    // the pre-edge mask so a release only becomes allocatable one cycle later.
    always_comb begin
        alloc_rdy = (state_q == RUN) && (|mask_q);
        // A flush in the same cycle wins; the coinciding request is not taken.
        accept    = alloc_req && alloc_rdy && !flush;
        grant     = mask_q & (~mask_q + 64'd1);
        rel_oh    = 64'd1 << rel_label;
        rel_ok    = (state_q == RUN) && rel_valid && (rel_label != 6'd0)
                    && !mask_q[rel_label];
`ifdef LABEL_ALLOCATOR_ERR_EN
        rel_bad   = (state_q == RUN) && rel_valid
                    && ((rel_label == 6'd0) || mask_q[rel_label]);
`endif
    end

    // Next-state and datapath update for the INIT/RUN/DRAIN controller.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        enc_d      = '0;
        vld_pipe_d = {vld_pipe_q[LAT-1:0], accept};
        // The last pipe stage coincides with the encoder result for that grant.
        av_d       = vld_pipe_q[LAT];
        al_d       = vld_pipe_q[LAT] ? enc_out : 6'd0;
`ifdef LABEL_ALLOCATOR_ERR_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            INIT: begin
                mask_d  = MASK_INIT;
                cnt_d   = CNT_INIT;
                state_d = RUN;
`ifdef LABEL_ALLOCATOR_ERR_EN
                err_d   = 1'b0;
`endif
            end
            RUN: begin
                if (accept) begin
                    mask_d = mask_d & ~grant;
                    enc_d  = grant;
                end
                if (rel_ok) begin
                    mask_d = mask_d | rel_oh;
                end
                unique case ({accept, rel_ok})
                    2'b10:   cnt_d = cnt_q - 7'd1;
                    2'b01:   cnt_d = cnt_q + 7'd1;
                    default: cnt_d = cnt_q;
                endcase
`ifdef LABEL_ALLOCATOR_ERR_EN
                if (rel_bad) begin
                    err_d = 1'b1;
                end
`endif
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_pipe_q == '0) begin
                    state_d = INIT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State registers; reset discards every in-flight grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            mask_q     <= MASK_INIT;
            cnt_q      <= CNT_INIT;
            enc_q      <= '0;
            vld_pipe_q <= '0;
            av_q       <= 1'b0;
            al_q       <= 6'd0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            enc_q      <= enc_d;
            vld_pipe_q <= vld_pipe_d;
            av_q       <= av_d;
            al_q       <= al_d;
        end
    end

`ifdef LABEL_ALLOCATOR_ERR_EN
    // Sticky double-free flag, cleared only by INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_double_free = err_q;
`endif

    assign alloc_valid = av_q;
    assign alloc_label = al_q;
    assign free_count  = cnt_q;
    assign enc_in      = enc_q;

endmodule

// File: tb/tb_label_allocator.sv
// Bench for label_allocator: directed scenarios plus a randomized run checked
// against a free-set model kept here. The external index encoder is modelled
// as a LAT-stage pipeline followed by a one-hot-to-index conversion.
module tb_label_allocator;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_req = 1'b0;
    logic        alloc_rdy;
    logic        alloc_valid;
    logic [5:0]  alloc_label;
    logic        rel_valid = 1'b0;
    logic [5:0]  rel_label = 6'd0;
    logic        flush = 1'b0;
    logic [6:0]  free_count;
    logic [63:0] enc_in;
    logic [5:0]  enc_out;
`ifdef LABEL_ALLOCATOR_ERR_EN
    logic        err_double_free;
`endif

    int n_checks = 0;
    int n_err = 0;
    longint cyc = 0;

    label_allocator #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_rdy(alloc_rdy),
        .alloc_valid(alloc_valid), .alloc_label(alloc_label),
        .rel_valid(rel_valid), .rel_label(rel_label),
        .flush(flush), .free_count(free_count),
        .enc_in(enc_in), .enc_out(enc_out)
`ifdef LABEL_ALLOCATOR_ERR_EN
        , .err_double_free(err_double_free)
`endif
    );

    always #5 clk = ~clk;

    // Edge counter: after edge e (sampled away from the edge) cyc == e.
    always @(posedge clk) cyc <= cyc + 1;

    // External encoder: LAT cycles from enc_in to enc_out.
    logic [63:0] enc_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) enc_pipe[i] = '0;
    always @(posedge clk) begin
        enc_pipe[0] <= enc_in;
        for (int i = 1; i < LAT; i++) enc_pipe[i] <= enc_pipe[i-1];
    end
    always_comb begin
        enc_out = 6'd0;
        for (int i = 0; i < 64; i++) if (enc_pipe[LAT-1][i]) enc_out = i[5:0];
    end

    // Observed grants, with the edge number after which each was seen.
    int     obs_lbl[$];
    longint obs_cyc[$];
    always @(negedge clk) if (alloc_valid) begin
        obs_lbl.push_back(int'(alloc_label));
        obs_cyc.push_back(cyc);
    end

    // Reference model: free set, mode, expected grant schedule.
    bit [63:0] m_free;
    int        m_mode;          // 0 = INIT, 1 = RUN, 2 = DRAIN
    bit        m_err;
    longint    m_last;          // edge of the most recent acceptance
    int        exp_lbl[$];
    longint    exp_due[$];
    bit        e_valid;
    int        e_label;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_free  <= ~64'd1;
            m_mode  <= 0;
            m_err   <= 1'b0;
            m_last  <= -1000;
            e_valid <= 1'b0;
            e_label <= 0;
            exp_lbl.delete();
            exp_due.delete();
        end else begin : mdl
            automatic longint e = cyc + 1;
            automatic bit [63:0] nf = m_free;
            automatic int lbl = 0;
            if (m_mode == 0) begin
                nf = ~64'd1;
                m_err  <= 1'b0;
                m_mode <= 1;
            end else if (m_mode == 1) begin
                if (rel_valid) begin
                    if (rel_label != 0 && !m_free[rel_label]) nf[rel_label] = 1'b1;
                    else m_err <= 1'b1;
                end
                if (alloc_req && m_free != 0 && !flush) begin
                    for (int i = 63; i >= 1; i--) if (m_free[i]) lbl = i;
                    nf[lbl] = 1'b0;
                    exp_lbl.push_back(lbl);
                    exp_due.push_back(e + LAT + 1);
                    m_last <= e;
                end
                if (flush) m_mode <= 2;
            end else if (m_last < e - LAT - 1) begin
                m_mode <= 0;
            end
            m_free  <= nf;
            e_valid <= 1'b0;
            if (exp_due.size() > 0 && exp_due[0] == e) begin
                e_valid <= 1'b1;
                e_label <= exp_lbl.pop_front();
                void'(exp_due.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_lbl.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 40 && obs_lbl.size() < n; i++) tick();
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 40 && !alloc_rdy; i++) tick();
    endtask

    task automatic do_reset();
        alloc_req = 0; rel_valid = 0; rel_label = 0; flush = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        clear_obs();
    endtask

    task automatic test_reset();
        alloc_req = 0; rel_valid = 0; flush = 0;
        rst_n = 0;
        tick();
        n_checks++;
        if (free_count !== 7'd63 || alloc_valid !== 1'b0 || enc_in !== 64'd0 || alloc_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: free_count=%0d valid=%b enc_in=%h rdy=%b, want 63 0 0 0",
                     free_count, alloc_valid, enc_in, alloc_rdy);
        end
`ifdef LABEL_ALLOCATOR_ERR_EN
        n_checks++;
        if (err_double_free !== 1'b0) begin
            n_err++; $display("FAIL reset_err: got %b want 0", err_double_free);
        end
`endif
        rst_n = 1;
        #1;
        n_checks++;
        if (alloc_rdy !== 1'b0) begin
            n_err++; $display("FAIL init_rdy: got %b want 0", alloc_rdy);
        end
        tick();
        n_checks++;
        if (alloc_rdy !== 1'b1 || free_count !== 7'd63) begin
            n_err++; $display("FAIL run_entry: rdy=%b free=%0d want 1 63", alloc_rdy, free_count);
        end
        clear_obs();
    endtask

    task automatic test_basic_alloc();
        longint a0;
        do_reset();
        alloc_req = 1;
        tick();
        a0 = cyc;
        n_checks++;
        if (enc_in !== 64'h2) begin
            n_err++; $display("FAIL enc_in_first: got %h want 2", enc_in);
        end
        tick(); tick();
        alloc_req = 0;
        n_checks++;
        if (free_count !== 7'd60) begin
            n_err++; $display("FAIL basic_count: got %0d want 60", free_count);
        end
        wait_obs(3);
        n_checks++;
        if (obs_lbl.size() != 3) begin
            n_err++; $display("FAIL basic_grants: got %0d pulses want 3", obs_lbl.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_lbl[i] != i + 1 || obs_cyc[i] != a0 + LAT + 1 + i) begin
                    n_err++;
                    $display("FAIL basic_grant%0d: label %0d at edge %0d, want label %0d at edge %0d",
                             i, obs_lbl[i], obs_cyc[i] - a0, i + 1, LAT + 1 + i);
                end
            end
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        alloc_req = 1;
        repeat (63) tick();
        n_checks++;
        if (alloc_rdy !== 1'b0 || free_count !== 7'd0) begin
            n_err++; $display("FAIL exhaust: rdy=%b free=%0d want 0 0", alloc_rdy, free_count);
        end
        repeat (3) tick();
        n_checks++;
        if (free_count !== 7'd0 || enc_in !== 64'd0) begin
            n_err++; $display("FAIL empty_hold: free=%0d enc_in=%h want 0 0", free_count, enc_in);
        end
        repeat (LAT + 3) tick();
        n_checks++;
        if (obs_lbl.size() != 63 || obs_lbl[$] != 63) begin
            n_err++; $display("FAIL exhaust_grants: got %0d pulses want 63 ending in 63", obs_lbl.size());
        end
        clear_obs();
        rel_valid = 1; rel_label = 6'd17;
        tick();
        rel_valid = 0;
        n_checks++;
        if (free_count !== 7'd1) begin
            n_err++; $display("FAIL release17_count: got %0d want 1", free_count);
        end
        tick();
        alloc_req = 0;
        n_checks++;
        if (free_count !== 7'd0 || enc_in !== (64'd1 << 17)) begin
            n_err++; $display("FAIL regrant17: free=%0d enc_in=%h want 0 %h", free_count, enc_in, 64'd1 << 17);
        end
        wait_obs(1);
        n_checks++;
        if (obs_lbl.size() != 1 || obs_lbl[0] != 17) begin
            n_err++; $display("FAIL regrant17_label: got %0d pulses first %0d want 17",
                              obs_lbl.size(), obs_lbl.size() ? obs_lbl[0] : -1);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        alloc_req = 1;
        repeat (9) tick();
        alloc_req = 0;
        repeat (LAT + 3) tick();
        n_checks++;
        if (free_count !== 7'd54) begin
            n_err++; $display("FAIL nine_count: got %0d want 54", free_count);
        end
        clear_obs();
        alloc_req = 1; rel_valid = 1; rel_label = 6'd5;
        tick();
        rel_valid = 0;
        n_checks++;
        if (free_count !== 7'd54) begin
            n_err++; $display("FAIL same_cycle_count: got %0d want 54", free_count);
        end
        tick();
        alloc_req = 0;
        n_checks++;
        if (free_count !== 7'd53) begin
            n_err++; $display("FAIL after_regrant_count: got %0d want 53", free_count);
        end
        wait_obs(2);
        n_checks++;
        if (obs_lbl.size() != 2 || obs_lbl[0] != 10 || obs_lbl[1] != 5) begin
            n_err++; $display("FAIL same_cycle_grants: got %p want 10 5", obs_lbl);
        end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_req = 1;
        repeat (3) tick();
        alloc_req = 0; flush = 1;
        tick();
        flush = 0;
        n_checks++;
        if (alloc_rdy !== 1'b0) begin
            n_err++; $display("FAIL drain_rdy: got %b want 0", alloc_rdy);
        end
        rel_valid = 1; rel_label = 6'd2;
        tick();
        rel_valid = 0;
        n_checks++;
        if (free_count !== 7'd60) begin
            n_err++; $display("FAIL drain_release_ignored: got %0d want 60", free_count);
        end
        wait_rdy();
        n_checks++;
        if (alloc_rdy !== 1'b1) begin
            n_err++; $display("FAIL flush_return: rdy never returned");
        end
        n_checks++;
        if (obs_lbl.size() != 3 || obs_lbl[0] != 1 || obs_lbl[2] != 3) begin
            n_err++; $display("FAIL flush_inflight: got %p before rdy, want 1 2 3", obs_lbl);
        end
        n_checks++;
        if (free_count !== 7'd63) begin
            n_err++; $display("FAIL flush_count: got %0d want 63", free_count);
        end
        clear_obs();
        alloc_req = 1;
        tick();
        alloc_req = 0;
        wait_obs(1);
        n_checks++;
        if (obs_lbl.size() != 1 || obs_lbl[0] != 1) begin
            n_err++; $display("FAIL flush_first_grant: got %p want 1", obs_lbl);
        end
    endtask

    task automatic test_err();
        do_reset();
        rel_valid = 1; rel_label = 6'd0;
        tick();
`ifdef LABEL_ALLOCATOR_ERR_EN
        n_checks++;
        if (err_double_free !== 1'b1) begin
            n_err++; $display("FAIL err_label0: got %b want 1", err_double_free);
        end
`endif
        rel_label = 6'd40;
        tick();
        rel_valid = 0;
        n_checks++;
        if (free_count !== 7'd63) begin
            n_err++; $display("FAIL bad_release_count: got %0d want 63", free_count);
        end
        repeat (3) tick();
`ifdef LABEL_ALLOCATOR_ERR_EN
        n_checks++;
        if (err_double_free !== 1'b1) begin
            n_err++; $display("FAIL err_sticky: got %b want 1", err_double_free);
        end
`endif
        flush = 1;
        tick();
        flush = 0;
        wait_rdy();
        n_checks++;
        if (alloc_rdy !== 1'b1 || free_count !== 7'd63) begin
            n_err++; $display("FAIL err_flush_return: rdy=%b free=%0d want 1 63", alloc_rdy, free_count);
        end
`ifdef LABEL_ALLOCATOR_ERR_EN
        n_checks++;
        if (err_double_free !== 1'b0) begin
            n_err++; $display("FAIL err_cleared: got %b want 0", err_double_free);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        do_reset();
        alloc_req = 1;
        tick(); tick();
        alloc_req = 0;
        tick();
        rst_n = 0;
        #1;
        n_checks++;
        if (free_count !== 7'd63 || alloc_valid !== 1'b0) begin
            n_err++; $display("FAIL midreset_values: free=%0d valid=%b want 63 0", free_count, alloc_valid);
        end
        tick();
        rst_n = 1;
        clear_obs();
        repeat (12) tick();
        n_checks++;
        if (obs_lbl.size() != 0 || free_count !== 7'd63) begin
            n_err++; $display("FAIL midreset_discard: pulses=%0d free=%0d want 0 63", obs_lbl.size(), free_count);
        end
        alloc_req = 1;
        tick();
        alloc_req = 0;
        wait_obs(1);
        n_checks++;
        if (obs_lbl.size() != 1 || obs_lbl[0] != 1) begin
            n_err++; $display("FAIL midreset_first_grant: got %p want 1", obs_lbl);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            flush     = ($urandom_range(0, 79) == 0);
            alloc_req = !flush && ($urandom_range(0, 9) < 6);
            rel_valid = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) == 0) begin
                rel_label = 6'($urandom_range(0, 63));
            end else begin
                automatic int s = $urandom_range(1, 63);
                rel_label = 6'(s);
                for (int k = 0; k < 63; k++) begin
                    automatic int l = ((s - 1 + k) % 63) + 1;
                    if (!m_free[l]) begin rel_label = 6'(l); break; end
                end
            end
            tick();
            n_checks++;
            if (alloc_rdy !== (m_mode == 1 && m_free != 0) ||
                free_count !== 7'($countones(m_free)) ||
                alloc_valid !== e_valid ||
                (e_valid && alloc_label !== 6'(e_label))) begin
                n_err++; bad++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d: rdy=%b free=%0d valid=%b label=%0d, want %b %0d %b %0d",
                             c, alloc_rdy, free_count, alloc_valid, alloc_label,
                             (m_mode == 1 && m_free != 0), $countones(m_free), e_valid, e_label);
            end
`ifdef LABEL_ALLOCATOR_ERR_EN
            n_checks++;
            if (err_double_free !== m_err) begin
                n_err++; $display("FAIL random_err%0d: got %b want %b", c, err_double_free, m_err);
            end
`endif
        end
        alloc_req = 0; rel_valid = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_basic_alloc();
        test_exhaust();
        test_same_cycle();
        test_flush();
        test_err();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
